// File: rtl/reflet_float_mult_arbiter_pkg.sv
// Shared definitions for the floating-point multiplier arbiter:
// FSM state encoding, counter width and a constant clog2 helper.
package reflet_float_mult_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latency counter width; covers mult_latency values 0..15.
    localparam int CNT_W = 4;

    // Ceiling log2 for sizing index fields. Never returns less than 1, so
    // that an id or pointer field always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/reflet_float_mult_arbiter_if.sv
// Client-side bus of the multiplier arbiter: per-client request and
// response handshakes, packed operands and the shared result.
interface reflet_float_mult_arbiter_if #(
    parameter int float_size = 32,
    parameter int requesters = 4
);
    logic [requesters-1:0]            req_valid;
    logic [requesters-1:0]            req_ready;
    logic [requesters*float_size-1:0] req_in1;
    logic [requesters*float_size-1:0] req_in2;
    logic [requesters-1:0]            resp_valid;
    logic [requesters-1:0]            resp_ready;
    logic [float_size-1:0]            resp_mult;

    // Clients drive requests and accept responses.
    modport master (
        output req_valid, req_in1, req_in2, resp_ready,
        input  req_ready, resp_valid, resp_mult
    );

    // The arbiter grants requests and presents responses.
    modport slave (
        input  req_valid, req_in1, req_in2, resp_ready,
        output req_ready, resp_valid, resp_mult
    );
endinterface

// File: rtl/reflet_rr_arbiter.sv
// Combinational round-robin picker: scans req_valid starting at rr_ptr,
// wrapping at n, and returns a one-hot grant plus its encoded id.
module reflet_rr_arbiter
    import reflet_float_mult_arbiter_pkg::*;
#(
    parameter int n    = 4,
    parameter int id_w = clog2(n)
) (
    input  logic [n-1:0]    req_valid,
    input  logic [id_w-1:0] rr_ptr,
    output logic [n-1:0]    grant,
    output logic [id_w-1:0] grant_id
);
    localparam int SW = id_w + 1;

    logic [SW-1:0]   scan_pos;
    logic [id_w-1:0] scan_idx;
    logic            found;

    // First asserted request at or after rr_ptr wins; one extra bit on the
    // scan position keeps the modulo-n wrap correct for non-power-of-two n.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_pos = '0;
        scan_idx = '0;
        for (int off = 0; off < n; off++) begin
            scan_pos = {1'b0, rr_ptr} + SW'(off);
            if (scan_pos >= SW'(n)) begin
                scan_pos = scan_pos - SW'(n);
            end
            scan_idx = scan_pos[id_w-1:0];
            if (!found && req_valid[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_id        = scan_idx;
            end
        end
    end
endmodule

// File: rtl/reflet_float_mult_arbiter.sv
// Shares one external floating-point multiplier among several clients.
// One operation at a time: grant round-robin, hold operands for the
// multiplier latency, capture the product, return it to the requester.
module reflet_float_mult_arbiter
    import reflet_float_mult_arbiter_pkg::*;
#(
    parameter int float_size   = 32,
    parameter int requesters   = 4,
    parameter int mult_latency = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    reflet_float_mult_arbiter_if.slave clients,
    output logic                  mult_enable,
    output logic [float_size-1:0] mult_in1,
    output logic [float_size-1:0] mult_in2,
    input  logic [float_size-1:0] mult_out
);
    localparam int ID_W = clog2(requesters);

    state_t                state_reg;
    state_t                state_next;
    logic [float_size-1:0] op1_reg;
    logic [float_size-1:0] op2_reg;
    logic [float_size-1:0] result_reg;
    logic [ID_W-1:0]       id_reg;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [CNT_W-1:0]      cnt_reg;

    logic [requesters-1:0] grant;
    logic [ID_W-1:0]       grant_id;
    logic                  handshake;
    logic                  accept;
    logic [float_size-1:0] in1_arr [requesters];
    logic [float_size-1:0] in2_arr [requesters];

    // Unpack operand slices and build the one-hot response valid.
    for (genvar gi = 0; gi < requesters; gi++) begin : g_client
        assign in1_arr[gi] = clients.req_in1[gi*float_size +: float_size];
        assign in2_arr[gi] = clients.req_in2[gi*float_size +: float_size];
        assign clients.resp_valid[gi] = (state_reg == RESP) && (id_reg == ID_W'(gi));
    end

    reflet_rr_arbiter #(
        .n    (requesters),
        .id_w (ID_W)
    ) u_rr_arbiter (
        .req_valid (clients.req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    // Grants are only offered while idle; only the served client can accept.
    assign clients.req_ready = (state_reg == IDLE) ? grant : '0;
    assign handshake         = (state_reg == IDLE) && (|grant);
    assign accept            = clients.resp_ready[id_reg];
    assign clients.resp_mult = result_reg;
    assign mult_enable       = (state_reg == BUSY);
    assign mult_in1          = op1_reg;
    assign mult_in2          = op2_reg;

    // Next-state logic for the IDLE -> BUSY -> RESP cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = BUSY;
            BUSY:    if (cnt_reg == '0) state_next = RESP;
            RESP:    if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand latch on grant, latency countdown and product capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op1_reg    <= '0;
            op2_reg    <= '0;
            result_reg <= '0;
            id_reg     <= '0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (handshake) begin
                op1_reg    <= in1_arr[grant_id];
                op2_reg    <= in2_arr[grant_id];
                id_reg     <= grant_id;
                rr_ptr_reg <= (grant_id == ID_W'(requesters - 1)) ? '0 : grant_id + ID_W'(1);
                cnt_reg    <= CNT_W'(mult_latency);
            end
            if (state_reg == BUSY) begin
                if (cnt_reg == '0) begin
                    result_reg <= mult_out;
                end else begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_reflet_float_mult_arbiter.sv
// Bench for reflet_float_mult_arbiter: three instances (latency 1, 0, 3),
// each behind a behavioural pipelined float multiplier. Instance 0 is fully
// scoreboarded; instances 1 and 2 check response latency only.
module tb_reflet_float_mult_arbiter;
    localparam int FS = 32;
    localparam int NR = 4;
    localparam int NI = 3;
    localparam int MAIN_LAT = 1;
    localparam logic [31:0] POISON = 32'h7FC0DEAD;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [NR-1:0]    req_valid  [NI];
    logic [NR-1:0]    req_ready  [NI];
    logic [NR*FS-1:0] req_in1    [NI];
    logic [NR*FS-1:0] req_in2    [NI];
    logic [NR-1:0]    resp_valid [NI];
    logic [NR-1:0]    resp_ready [NI];
    logic [FS-1:0]    resp_mult  [NI];
    logic             mult_enable[NI];
    logic [FS-1:0]    mult_in1   [NI];
    logic [FS-1:0]    mult_in2   [NI];
    logic [FS-1:0]    mult_out   [NI];

    // Normal-numbers-only float multiply (truncating); stands in for the
    // external multiplier datapath.
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
        return {a[31] ^ b[31], e[7:0], p[45:23]};
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
        localparam int TAP = (LAT == 0) ? 0 : LAT - 1;
        logic [32:0] stg [4];

        reflet_float_mult_arbiter_if #(.float_size(FS), .requesters(NR)) bus ();

        assign bus.req_valid  = req_valid[gi];
        assign bus.req_in1    = req_in1[gi];
        assign bus.req_in2    = req_in2[gi];
        assign bus.resp_ready = resp_ready[gi];
        assign req_ready[gi]  = bus.req_ready;
        assign resp_valid[gi] = bus.resp_valid;
        assign resp_mult[gi]  = bus.resp_mult;

        reflet_float_mult_arbiter #(
            .float_size(FS), .requesters(NR), .mult_latency(LAT)
        ) dut (
            .clk(clk), .reset(reset), .clients(bus),
            .mult_enable(mult_enable[gi]), .mult_in1(mult_in1[gi]),
            .mult_in2(mult_in2[gi]), .mult_out(mult_out[gi])
        );

        // Pipelined multiplier model; output is POISON unless it carries a
        // product computed from operands presented with enable high.
        always @(posedge clk) begin
            if (!reset) begin
                stg[0] <= '0; stg[1] <= '0; stg[2] <= '0; stg[3] <= '0;
            end else begin
                stg[0] <= {mult_enable[gi], fmul(mult_in1[gi], mult_in2[gi])};
                stg[1] <= stg[0];
                stg[2] <= stg[1];
                stg[3] <= stg[2];
            end
        end
        assign mult_out[gi] = (LAT == 0)
            ? (mult_enable[gi] ? fmul(mult_in1[gi], mult_in2[gi]) : POISON)
            : (stg[TAP][32] ? stg[TAP][31:0] : POISON);
    end

    task automatic check32(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int oh_idx(logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    typedef struct { logic [1:0] id; logic [31:0] a; logic [31:0] b; } grant_t;
    typedef struct { logic [1:0] id; logic [31:0] p; } resp_t;
    grant_t exp_grant[$];
    resp_t  exp_resp[$];

    // Monitor for instance 0: pops expected grants/responses as the DUT presents them.
    int          hs_cycle = 0;
    int          en_cnt = 0;
    bit          in_flight = 0;
    bit          resp_seen = 0;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;

    always @(negedge clk) begin
        grant_t g;
        int     gidx;
        int     ridx;
        logic [1:0] rid;
        if (!reset) begin
            in_flight = 0;
            resp_seen = 0;
        end else begin
            check32("grant_legal",
                    32'(($countones(req_ready[0]) <= 1) && ((req_ready[0] & ~req_valid[0]) == '0)), 32'd1);
            if ((req_ready[0] & req_valid[0]) != '0) begin
                gidx = oh_idx(req_ready[0]);
                if (in_flight || exp_grant.size() == 0) begin
                    check32("grant_unexpected", 32'(gidx), 32'hFFFF_FFFF);
                end else begin
                    g = exp_grant.pop_front();
                    check32("grant_id", 32'(gidx), 32'(g.id));
                    in_flight = 1; resp_seen = 0;
                    hs_cycle = cyc; en_cnt = 0;
                    cur_a = g.a; cur_b = g.b;
                end
            end
            if (mult_enable[0]) begin
                en_cnt++;
                check32("enable_in_flight", 32'(in_flight), 32'd1);
                check32("mult_in1", mult_in1[0], cur_a);
                check32("mult_in2", mult_in2[0], cur_b);
            end
            if (resp_valid[0] != '0) begin
                ridx = oh_idx(resp_valid[0]);
                if (!in_flight || exp_resp.size() == 0 || ridx < 0) begin
                    check32("resp_unexpected", 32'(resp_valid[0]), 32'd0);
                end else begin
                    rid = ridx[1:0];
                    check32("resp_id", 32'(rid), 32'(exp_resp[0].id));
                    check32("resp_mult", resp_mult[0], exp_resp[0].p);
                    check32("resp_exclusive", 32'({mult_enable[0], req_ready[0]}), 32'd0);
                    if (!resp_seen) begin
                        resp_seen = 1;
                        check32("resp_latency", 32'(cyc - hs_cycle), 32'(MAIN_LAT + 2));
                        check32("enable_cycles", 32'(en_cnt), 32'(MAIN_LAT + 1));
                    end
                    if (resp_ready[0][rid]) begin
                        void'(exp_resp.pop_front());
                        in_flight = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(logic [1:0] id, logic [31:0] a, logic [31:0] b);
        req_in1[0][id*FS +: FS] = a;
        req_in2[0][id*FS +: FS] = b;
    endtask

    task automatic expect_op(logic [1:0] id, logic [31:0] a, logic [31:0] b, logic [31:0] p);
        grant_t g;
        resp_t  r;
        g.id = id; g.a = a; g.b = b;
        r.id = id; r.p = p;
        exp_grant.push_back(g);
        exp_resp.push_back(r);
    endtask

    // Single request from one client; returns one cycle after the grant.
    task automatic issue(logic [1:0] id, logic [31:0] a, logic [31:0] b, logic [31:0] p);
        bit ok;
        set_ops(id, a, b);
        expect_op(id, a, b, p);
        req_valid[0][id] = 1'b1;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[0][id]) ok = 1;
        end
        if (!ok) check32("grant_timeout", 32'(id), 32'hFFFF_FFFF);
        tick();
        req_valid[0][id] = 1'b0;
    endtask

    // Hold a request mask until n handshakes have been seen.
    task automatic run_burst(logic [3:0] mask, int n);
        int seen;
        seen = 0;
        req_valid[0] = mask;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if ((req_ready[0] & req_valid[0]) != '0) seen++;
        end
        check32("burst_grants", 32'(seen), 32'(n));
        tick();
        req_valid[0] = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_resp.size() != 0; i++) @(negedge clk);
        check32("drain", 32'(exp_resp.size()), 32'd0);
        tick();
    endtask

    task automatic wait_resp(logic [3:0] want);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid[0] == want) ok = 1;
        end
        if (!ok) check32("resp_timeout", 32'(resp_valid[0]), 32'(want));
    endtask

    task automatic check_reset(logic [1:0] k);
        check32("rst_req_ready", 32'(req_ready[k]), 32'd0);
        check32("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
        check32("rst_resp_mult", resp_mult[k], 32'd0);
        check32("rst_mult_enable", 32'(mult_enable[k]), 32'd0);
        check32("rst_mult_in1", mult_in1[k], 32'd0);
        check32("rst_mult_in2", mult_in2[k], 32'd0);
    endtask

    // Latency check on a secondary instance: 0.5 x 4.0 = 2.0 on client 0.
    task automatic lat_test(logic [1:0] k, int lat);
        int t;
        int r;
        t = -1; r = -1;
        req_in1[k][31:0] = 32'h3F000000;
        req_in2[k][31:0] = 32'h40800000;
        resp_ready[k] = 4'b0001;
        req_valid[k] = 4'b0001;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if (req_ready[k][0]) t = cyc;
        end
        tick();
        req_valid[k] = '0;
        for (int i = 0; i < 40 && r < 0; i++) begin
            @(negedge clk);
            if (resp_valid[k][0]) r = cyc;
        end
        check32("lat_grant_seen", 32'(t >= 0), 32'd1);
        check32("lat_resp_cycle", 32'(r - t), 32'(lat + 2));
        check32("lat_resp_mult", resp_mult[k], 32'h40000000);
        tick();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = '0; req_in1[k] = '0; req_in2[k] = '0; resp_ready[k] = '1;
        end
        repeat (3) tick();
        @(negedge clk);
        check_reset(2'd0);
        check_reset(2'd2);
        tick();
        reset = 1'b1;
        tick();

        // All four clients continuously valid: grants 0,1,2,3,0.
        set_ops(2'd0, 32'h3F800000, 32'h40000000);
        set_ops(2'd1, 32'hC0000000, 32'h40400000);
        set_ops(2'd2, 32'h3FC00000, 32'h3FC00000);
        set_ops(2'd3, 32'h40000000, 32'h40000000);
        expect_op(2'd0, 32'h3F800000, 32'h40000000, 32'h40000000);
        expect_op(2'd1, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        expect_op(2'd2, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        expect_op(2'd3, 32'h40000000, 32'h40000000, 32'h40800000);
        expect_op(2'd0, 32'h3F800000, 32'h40000000, 32'h40000000);
        run_burst(4'b1111, 5);
        wait_drain();

        // Single client 0: 1.0 x 2.0.
        issue(2'd0, 32'h3F800000, 32'h40000000, 32'h40000000);
        wait_drain();

        // Latency 0 and 3 instances.
        lat_test(2'd1, 0);
        lat_test(2'd2, 3);

        // Client 2 stalled by resp_ready low; client 0 waits meanwhile.
        resp_ready[0] = '0;
        issue(2'd2, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        set_ops(2'd0, 32'h40000000, 32'h40000000);
        expect_op(2'd0, 32'h40000000, 32'h40000000, 32'h40800000);
        req_valid[0][0] = 1'b1;
        wait_resp(4'b0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("stall_valid", 32'(resp_valid[0]), 32'h4);
            check32("stall_mult", resp_mult[0], 32'h40100000);
            check32("stall_no_grant", 32'(req_ready[0]), 32'd0);
        end
        tick();
        resp_ready[0] = '1;
        run_burst(4'b0001, 1);
        wait_drain();

        // Client 1 response while only client 3 is ready: must hold.
        resp_ready[0] = 4'b1000;
        issue(2'd1, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        wait_resp(4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("foreign_ready_hold", 32'(resp_valid[0]), 32'h2);
        end
        tick();
        resp_ready[0] = 4'b0010;
        wait_drain();
        resp_ready[0] = '1;

        // Reset during BUSY: nothing returned; pointer restarts at 0.
        issue(2'd1, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        reset = 1'b0;
        void'(exp_resp.pop_back());
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_reset(2'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check32("no_resp_after_reset", 32'(resp_valid[0]), 32'd0);
        end
        tick();
        set_ops(2'd0, 32'h3F000000, 32'h40800000);
        set_ops(2'd2, 32'h3FC00000, 32'h3FC00000);
        expect_op(2'd0, 32'h3F000000, 32'h40800000, 32'h40000000);
        expect_op(2'd2, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
        run_burst(4'b0101, 2);
        wait_drain();

        check32("grants_consumed", 32'(exp_grant.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/reflet_float_mult_arbiter.md
# reflet_float_mult_arbiter

Shares one floating-point multiplier among `requesters` clients, one operation at a time. Clients use a valid/ready handshake and are served round-robin. The block latches the granted operands, drives the multiplier for a configurable pipeline latency, captures the product and returns it to the originating client through a response handshake. It sits between the multiplier datapath and the FPU front-end or any other clients that need multiplication.

## Interface
- `float_size`, 32: float width; the multiplier uses the same value.
- `requesters`, 4: number of clients, 2..8.
- `mult_latency`, 1: cycles from a stable `mult_in1`/`mult_in2` to a valid `mult_out`, 0..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  `requesters`  per-client request.
- `req_ready`  out  `requesters`  per-client grant; one-hot or zero.
- `req_in1`  in  `requesters*float_size`  packed first operands; client i uses slice i.
- `req_in2`  in  `requesters*float_size`  packed second operands.
- `resp_valid`  out  `requesters`  per-client result valid; one-hot or zero.
- `resp_ready`  in  `requesters`  per-client result accept.
- `resp_mult`  out  `float_size`  result, shared by all clients.
- `mult_enable`  out  1  enable to the multiplier.
- `mult_in1`, `mult_in2`  out  `float_size`  multiplier operands.
- `mult_out`  in  `float_size`  multiplier result.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - Round-robin pick among the asserted `req_valid` bits, starting at pointer `rr_ptr`.
  - Assert `req_ready` for the picked client only; `req_ready` depends combinationally on `req_valid`.
  - On handshake: latch `req_in1`/`req_in2` slice into the operand registers, store the client id, set `rr_ptr` = (id+1) mod `requesters`, load `cnt` = `mult_latency`, go to BUSY.
- BUSY:
  - `mult_enable`=1 and `mult_in1`/`mult_in2` = operand registers, held stable.
  - `req_ready`=0.
  - If `cnt`==0: capture `mult_out` into the result register and go to RESP. Otherwise `cnt`-=1.
- RESP:
  - `resp_valid[id]`=1, `resp_mult` = result register.
  - Hold until `resp_ready[id]`, then go to IDLE.
  - `resp_ready` bits of other clients are ignored.
- `mult_enable`=0 outside BUSY. `mult_in1`/`mult_in2` always show the operand registers.
- No arithmetic is done in this block. Zero, sign and exponent handling belong to the multiplier. `resp_mult` is bit-exact `mult_out`.
- `cnt` is 4 bits. `rr_ptr` is clog2(`requesters`) bits and wraps from `requesters`-1 to 0.

## Timing
- Reset values: `req_ready`=0 (the state is IDLE, but it is driven only from the arbitration result), `resp_valid`=0, `resp_mult`=0, `mult_enable`=0, `mult_in1`=`mult_in2`=0, `rr_ptr`=0, `cnt`=0.
- Handshake in cycle T:
  - BUSY from T+1 to T+1+`mult_latency`.
  - Capture at the end of cycle T+1+`mult_latency`.
  - `resp_valid` first high in T+2+`mult_latency`.
- Accept in cycle R: IDLE in R+1, so the earliest next grant is R+1. Back-to-back throughput is one op per `mult_latency`+3 cycles.
- `req_valid` dropped before a grant: no effect, and no obligation to stay asserted. `req_valid` from the client currently in service is ignored until IDLE.
- Reset low in any state: IDLE next cycle. In-flight operation and pending response are discarded, with no `resp_valid`.
- `mult_latency`=0: BUSY lasts one cycle, response in T+2.

## Structure
- Shared header with the float functions: FSM state localparams (IDLE=0, BUSY=1, RESP=2) and a `clog2` function.
- Sub-module `reflet_rr_arbiter`: input `req_valid` and `rr_ptr`; output one-hot grant and encoded id. Purely combinational and reusable.
- The multiplier stays outside; the top level connects `mult_*` to `reflet_float_mult`.

## Test plan
- Client 0: 0x3F800000 × 0x40000000 with `mult_latency`=1 -> handshake at T, `resp_valid[0]` at T+3, `resp_mult`=0x40000000, `mult_enable` high for exactly T+1..T+2.
- All four clients valid continuously, each client with its own operands -> grants in order 0,1,2,3,0, each result routed to the correct `resp_valid` bit.
- Client 2: 0x3FC00000 × 0x3FC00000 with `resp_ready` held low 5 cycles -> `resp_valid[2]` and `resp_mult`=0x40100000 stable for all 5 cycles, no new grant until IDLE.
- Client 1: 0xC0000000 × 0x40400000 -> 0xC0C00000. A simultaneous `resp_ready[3]` has no effect.
- Reset pulsed low during BUSY -> no `resp_valid`, all outputs at reset values, next request is served with `rr_ptr` restarting at 0.
- `mult_latency`=0 and 3 variants -> `resp_valid` at T+2 and T+5 respectively.
